// File: rtl/clock_enable_generator_pkg.sv
// Shared types, default constants and helpers for the programmable clock-enable generator.
package clkgen_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int DEFAULT_DIV   = 2;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

    // Ceil(n/2): length of the INIT_STATE phase of the square output.
    function automatic logic [31:0] half_period(input logic [31:0] n);
        return (n >> 1) + {31'b0, n[0]};
    endfunction

endpackage

// File: rtl/clock_enable_generator_if.sv
// Per-channel control and status bundle of the clock-enable generator.
interface clock_enable_generator_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*DIV_W-1:0] divisor;
    logic [NUM_CH-1:0]       load;
    logic                    sync_restart;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       square;
    logic [NUM_CH-1:0]       pending;

    modport master (
        output enable, divisor, load, sync_restart,
        input  tick, square, pending
    );

    modport slave (
        input  enable, divisor, load, sync_restart,
        output tick, square, pending
    );
endinterface

// File: rtl/clock_enable_generator_channel.sv
// One divider channel: period counter, active/pending divisor and registered tick/square outputs.
module clock_divider_channel
    import clkgen_pkg::*;
#(
    parameter int   DIV_W       = DIV_W_DEFAULT,
    parameter int   DEFAULT_DIV = 2,
    parameter logic INIT_STATE  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic             load_i,
    input  logic             sync_restart_i,
    output logic             tick_o,
    output logic             square_o,
    output logic             pending_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic             run;
    logic             boundary;
    logic             apply;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half;

    always_comb begin
        run      = enable_i && (div_act_q != '0);
        boundary = (cnt_q == div_act_q - DIV_W'(1));
        cnt_inc  = boundary ? '0 : cnt_q + DIV_W'(1);
        half     = DIV_W'(half_period(32'(div_act_q)));
        // Pending divisor lands on restart, while idle, or at the end of the running period.
        apply    = pend_q && (sync_restart_i || !run || boundary);

        cnt_d      = '0;
        tick_d     = 1'b0;
        sq_d       = INIT_STATE;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;

        if (!sync_restart_i && run) begin
            cnt_d  = cnt_inc;
            tick_d = boundary;
            sq_d   = (cnt_inc < half) ? INIT_STATE : ~INIT_STATE;
        end

        if (apply) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
        end

        // A fresh load always wins the pending slot, even on the edge that consumes the old one.
        if (load_i) begin
            div_pend_d = divisor_i;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_W'(DEFAULT_DIV);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= INIT_STATE;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
        end
    end

    assign tick_o    = tick_q;
    assign square_o  = sq_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clock_enable_generator.sv
// Multi-channel clock-enable generator: NUM_CH independent dividers sharing clock, reset and restart.
module clock_enable_generator
    import clkgen_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   DIV_W       = DIV_W_DEFAULT,
    parameter int   DEFAULT_DIV = 2,
    parameter logic INIT_STATE  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    clock_enable_generator_if.slave   bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_divider_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .INIT_STATE  (INIT_STATE)
        ) u_ch (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .enable_i       (bus.enable[i]),
            .divisor_i      (bus.divisor[i*DIV_W +: DIV_W]),
            .load_i         (bus.load[i]),
            .sync_restart_i (bus.sync_restart),
            .tick_o         (bus.tick[i]),
            .square_o       (bus.square[i]),
            .pending_o      (bus.pending[i])
        );
    end

endmodule

// File: doc/clock_enable_generator.md
Name: clock_enable_generator

Overview:
- Synthesizable, multi-channel programmable clock-enable generator, driven from a single system clock.
- Each channel outputs a one-cycle Tick strobe every N cycles and a near-50% Square waveform.
- Per-channel divisors can be changed at run time; the change takes effect glitch-free at the next period boundary.
- Sits beside the CPU core. Supplies timer, UART-baud and display-scan enables without gating the clock.

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- DIV_W, 16: divisor width in bits; period N ranges 1..2^DIV_W-1.
- DEFAULT_DIV, 2: divisor loaded into every channel at reset.
- INIT_STATE, 1'b1: Square level during the first half-period and whenever a channel is idle.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous active-low reset; sampled on the rising edge of Clock.
- Enable  in  NUM_CH  per-channel run enable.
- Divisor  in  NUM_CH*DIV_W  new period N per channel; channel i occupies bits [i*DIV_W +: DIV_W].
- Load  in  NUM_CH  one-cycle strobe; captures Divisor[i] as channel i's pending divisor.
- SyncRestart  in  1  realigns all channels to count 0.
- Tick  out  NUM_CH  registered; high for exactly one cycle per period.
- Square  out  NUM_CH  registered divided clock.
- Pending  out  NUM_CH  registered; high while a loaded divisor is waiting to be applied.

Behaviour:
- Reset (Reset_n low at an edge):
  - Count=0, DivActive=DEFAULT_DIV, Pending=0.
  - Tick=0, Square=INIT_STATE on all channels.
  - Reset overrides every other input, including mid-period and while a divisor is pending.
- Per-channel state: Count (DIV_W bits), DivActive, DivPending, Pending flag.
- Run state (Enable[i]=1 and DivActive!=0):
  - Each edge: if Count==DivActive-1 then Count<=0, else Count<=Count+1.
  - Tick[i] <= (Count==DivActive-1).
  - Square[i] <= INIT_STATE if next Count < ceil(DivActive/2), else ~INIT_STATE.
  - Square is therefore high-phase for ceil(N/2) cycles and low-phase for floor(N/2) cycles.
- Timing: the first Tick is visible during the N-th cycle after Enable is first sampled high (Count starts at 0). After that, Tick repeats exactly every N cycles.
- N=1: Tick stays high continuously; Square stays at INIT_STATE.
- Idle state (Enable[i]=0 or DivActive==0):
  - Count<=0, Tick<=0, Square<=INIT_STATE on the next edge.
  - Re-enabling restarts the channel from the start of a period.
- Divisor 0 means the channel is idle even when Enable is high.
- Load[i] at an edge:
  - DivPending<=Divisor slice; Pending<=1.
  - A second Load before the pending value is applied overwrites it (last write wins).
- Applying a pending divisor (DivActive<=DivPending, Pending<=0):
  - In run state: on the edge where Count==DivActive-1 (period boundary). The current period always completes at the old N.
  - In idle state: on the next edge.
- Load and boundary on the same edge:
  - The previous pending value, if any, is applied.
  - The new value becomes pending.
  - If nothing was pending, the new value waits for the following boundary.
- SyncRestart=1 at an edge:
  - Every channel: Count<=0, Tick<=0, Square<=INIT_STATE.
  - Pending divisors are applied immediately.
  - Takes priority over boundary logic; a Load on the same edge is captured as pending.
- Tick and Square are pure flop outputs, with no combinational path from any input.

Decomposition:
- Shared package clkgen_pkg:
  - typedef div_t (logic [DIV_W-1:0]).
  - Constants DIV_W_DEFAULT and DEFAULT_DIV.
  - Function half_period(N), returning ceil(N/2).
- One sub-module, clock_divider_channel, holding a single channel's counter, divisor registers and outputs.
- Top level instantiates NUM_CH channels in a generate loop and fans out Clock, Reset_n and SyncRestart.

Test Plan:
- Reset held 3 cycles, then Enable=4'b0001 with DEFAULT_DIV=2 -> Tick[0] high every 2nd cycle from cycle 2; Square[0] toggles every cycle starting from 1; other channels Tick=0, Square=1.
- Divisor[0]=5 with Load in mid-period while running at N=2 -> Pending[0]=1 until the boundary; the current period completes at 2, then Ticks are 5 apart; Square is high 3 cycles, low 2.
- Enable all channels with N=1, 3, 0, 7 -> ch0 Tick constantly high; ch1 Tick every 3 cycles; ch2 idle (Tick 0, Square INIT_STATE); ch3 Tick every 7 cycles.
- Load 9 then Load 6 on consecutive cycles before the boundary -> the channel applies 6 only; Pending clears at the boundary.
- SyncRestart while channels are mid-count with a pending divisor -> all Counts zero; the pending divisor applies at once; first Tick follows N cycles later, with all channels aligned.
- Reset_n low mid-period with Pending=1 -> next cycle Tick=0, Square=INIT_STATE, Pending=0, DivActive back to 2.
